// File: rtl/sata_tx_align_scheduler.sv
// -----------------------------------------------------------------------------
// sata_tx_align_scheduler
//
// Purpose:
//    Sits between the 32-bit link-layer TX stream and the 16-bit transceiver TX
//    port, in the PHY_CLK domain. Each DWORD slot is sent as two half-words,
//    low half first. A pair of ALIGN primitives is inserted every
//    ALIGN_INTERVAL data DWORDs, when FORCE_ALIGN asks for one, and whenever
//    the link comes up. The link layer is back-pressured with a per-DWORD
//    accept strobe, so it never has to know that ALIGNs are being inserted.
//
// Ports:
//    PHY_CLK        in   transceiver-rate clock, one half-word per cycle
//    RESET          in   asynchronous, active-high reset
//    LINKUP         in   PHY ready; low holds the block in LINK_DOWN
//    TX_DW_IN       in   [31:0] next DWORD from the link layer
//    TX_DW_ISK      in   byte0 of TX_DW_IN is a K character
//    FORCE_ALIGN    in   request an ALIGN pair at the next slot boundary
//    DW_ACCEPT      out  TX_DW_IN/TX_DW_ISK are consumed on this edge
//    TX_DATA_OUT    out  [15:0] half-word to the transceiver
//    TX_CHARISK_OUT out  [1:0] per-byte K flags for TX_DATA_OUT
//    TX_PHASE       out  0 = low half-word on TX_DATA_OUT, 1 = high half-word
//    ALIGN_ACTIVE   out  the half-word on TX_DATA_OUT belongs to an ALIGN
//    ALIGN_DONE     out  one-cycle pulse once the second ALIGN of a pair is out
// -----------------------------------------------------------------------------
module sata_tx_align_scheduler #(
   parameter int unsigned ALIGN_INTERVAL = 256,
   parameter logic [31:0] ALIGN_PRIM     = 32'h7B4A4ABC,
   parameter int unsigned CNT_W          = 9
) (
   input  logic        PHY_CLK,
   input  logic        RESET,
   input  logic        LINKUP,
   input  logic [31:0] TX_DW_IN,
   input  logic        TX_DW_ISK,
   input  logic        FORCE_ALIGN,
   output logic        DW_ACCEPT,
   output logic [15:0] TX_DATA_OUT,
   output logic [1:0]  TX_CHARISK_OUT,
   output logic        TX_PHASE,
   output logic        ALIGN_ACTIVE,
   output logic        ALIGN_DONE
);

   // The state names the kind of DWORD currently held in cur_dw.
   // LINK_DOWN also holds ALIGN_PRIM, so the first ALIGN of a link-up pair is
   // already in place on the edge LINKUP is first seen high.
   typedef enum logic [1:0] {
      LINK_DOWN,
      ALIGN0,
      ALIGN1,
      DATA
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALIGN_INTERVAL - 1);

   state_t           state, state_nxt;
   logic             phase, phase_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             force_pend, force_nxt;
   logic [31:0]      cur_dw, cur_dw_nxt;
   logic             cur_k, cur_k_nxt;
   logic             done_nxt;
   logic             data_next;

   logic [31:0]      out_word;
   logic             out_k;
   logic             out_sel;
   logic             out_active;

   // ---------------------------------------------------------------------------
   // Whether the slot that starts at the next boundary is a data slot.
   // cnt holds (data DWORDs since the last pair) - 1, so CNT_LAST means the
   // interval is used up.
   // ---------------------------------------------------------------------------
   always_comb begin
      data_next = 1'b0;
      case (state)
         ALIGN1:  data_next = 1'b1;
         DATA:    data_next = (cnt != CNT_LAST) && !force_pend;
         default: data_next = 1'b0;
      endcase
   end

   // phase is only ever 1 while linked, but LINKUP may drop in that same cycle.
   assign DW_ACCEPT = phase && LINKUP && data_next;

   // ---------------------------------------------------------------------------
   // State register and slot contents
   // ---------------------------------------------------------------------------
   always_ff @(posedge PHY_CLK or posedge RESET) begin
      if (RESET) begin
         state      <= LINK_DOWN;
         phase      <= 1'b0;
         cnt        <= '0;
         force_pend <= 1'b0;
         cur_dw     <= ALIGN_PRIM;
         cur_k      <= 1'b1;
      end else begin
         state      <= state_nxt;
         phase      <= phase_nxt;
         cnt        <= cnt_nxt;
         force_pend <= force_nxt;
         cur_dw     <= cur_dw_nxt;
         cur_k      <= cur_k_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt  = state;
      phase_nxt  = phase;
      cnt_nxt    = cnt;
      force_nxt  = force_pend;
      cur_dw_nxt = cur_dw;
      cur_k_nxt  = cur_k;
      done_nxt   = 1'b0;

      if (!LINKUP) begin
         // Any partially sent DWORD is dropped; the link restarts from scratch.
         state_nxt  = LINK_DOWN;
         phase_nxt  = 1'b0;
         cnt_nxt    = '0;
         force_nxt  = 1'b0;
         cur_dw_nxt = ALIGN_PRIM;
         cur_k_nxt  = 1'b1;
      end else begin
         phase_nxt = ~phase;

         case (state)
            LINK_DOWN: begin
               state_nxt = ALIGN0;
            end

            ALIGN0: begin
               if (phase) begin
                  state_nxt  = ALIGN1;
                  cur_dw_nxt = ALIGN_PRIM;
                  cur_k_nxt  = 1'b1;
               end
            end

            ALIGN1: begin
               if (phase) begin
                  state_nxt  = DATA;
                  cur_dw_nxt = TX_DW_IN;
                  cur_k_nxt  = TX_DW_ISK;
                  cnt_nxt    = '0;
                  done_nxt   = 1'b1;
               end
            end

            DATA: begin
               if (phase) begin
                  if (data_next) begin
                     cur_dw_nxt = TX_DW_IN;
                     cur_k_nxt  = TX_DW_ISK;
                     cnt_nxt    = cnt + 1'b1;
                  end else begin
                     state_nxt  = ALIGN0;
                     cur_dw_nxt = ALIGN_PRIM;
                     cur_k_nxt  = 1'b1;
                  end
               end
            end

            default: begin
               state_nxt = LINK_DOWN;
            end
         endcase

         // Entering a pair consumes any request, including one arriving on the
         // same edge; requests made while a pair is already running are dropped.
         if (state_nxt == ALIGN0) begin
            force_nxt = 1'b0;
         end else if (state == DATA && FORCE_ALIGN) begin
            force_nxt = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output half-word selection.
   // While the link is down the internal phase is parked at 0, but the
   // transceiver must still see the full ALIGN, so the half select alternates on
   // its own (TX_PHASE follows it). On the edge the link drops the low half is
   // forced so the abandoned DWORD is replaced immediately.
   // ---------------------------------------------------------------------------
   always_comb begin
      out_word   = cur_dw;
      out_k      = cur_k;
      out_sel    = phase;
      out_active = (state != DATA);
      if (!LINKUP) begin
         out_word   = ALIGN_PRIM;
         out_k      = 1'b1;
         out_sel    = (state == LINK_DOWN) ? ~TX_PHASE : 1'b0;
         out_active = 1'b1;
      end
   end

   always_ff @(posedge PHY_CLK or posedge RESET) begin
      if (RESET) begin
         TX_DATA_OUT    <= ALIGN_PRIM[15:0];
         TX_CHARISK_OUT <= 2'b01;
         TX_PHASE       <= 1'b0;
         ALIGN_ACTIVE   <= 1'b1;
         ALIGN_DONE     <= 1'b0;
      end else begin
         TX_DATA_OUT    <= out_sel ? out_word[31:16] : out_word[15:0];
         TX_CHARISK_OUT <= (!out_sel && out_k) ? 2'b01 : 2'b00;
         TX_PHASE       <= out_sel;
         ALIGN_ACTIVE   <= out_active;
         ALIGN_DONE     <= done_nxt;
      end
   end

endmodule

// File: tb/tb_sata_tx_align_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sata_tx_align_scheduler
//
// Purpose:
//    Self-checking bench for sata_tx_align_scheduler. A slot-level model tracks
//    what kind of slot is on the wire, how many data DWORDs have gone out since
//    the last ALIGN pair, and how many ALIGNs of the current pair remain. The
//    source is an incrementing DWORD counter that advances on DW_ACCEPT.
// -----------------------------------------------------------------------------
module tb_sata_tx_align_scheduler;

   localparam int unsigned INTERVAL = 256;
   localparam logic [31:0] AP       = 32'h7B4A4ABC;
   localparam logic [15:0] AP_LO    = AP[15:0];
   localparam logic [15:0] AP_HI    = AP[31:16];

   logic        PHY_CLK = 1'b0;
   logic        RESET;
   logic        LINKUP;
   logic [31:0] TX_DW_IN;
   logic        TX_DW_ISK;
   logic        FORCE_ALIGN;
   logic        DW_ACCEPT;
   logic [15:0] TX_DATA_OUT;
   logic [1:0]  TX_CHARISK_OUT;
   logic        TX_PHASE;
   logic        ALIGN_ACTIVE;
   logic        ALIGN_DONE;

   sata_tx_align_scheduler #(
      .ALIGN_INTERVAL (INTERVAL),
      .ALIGN_PRIM     (AP),
      .CNT_W          (9)
   ) dut (
      .PHY_CLK        (PHY_CLK),
      .RESET          (RESET),
      .LINKUP         (LINKUP),
      .TX_DW_IN       (TX_DW_IN),
      .TX_DW_ISK      (TX_DW_ISK),
      .FORCE_ALIGN    (FORCE_ALIGN),
      .DW_ACCEPT      (DW_ACCEPT),
      .TX_DATA_OUT    (TX_DATA_OUT),
      .TX_CHARISK_OUT (TX_CHARISK_OUT),
      .TX_PHASE       (TX_PHASE),
      .ALIGN_ACTIVE   (ALIGN_ACTIVE),
      .ALIGN_DONE     (ALIGN_DONE)
   );

   always #5 PHY_CLK = ~PHY_CLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Slot-level reference model
   // ---------------------------------------------------------------------------
   bit          m_up;        // link considered established
   bit          m_half;      // 0: low half of the slot goes out next, 1: high
   logic [31:0] m_slot;      // DWORD in the current slot
   bit          m_slot_k;
   bit          m_slot_al;   // current slot is an ALIGN
   int          m_al_after;  // ALIGNs of the pair still to follow this slot
   int          m_ndata;     // data DWORDs sent since the last pair
   bit          m_force_p;

   logic [15:0] e_data;
   logic [1:0]  e_k;
   bit          e_ph, e_act, e_done;

   task automatic model_reset();
      m_up = 0; m_half = 0; m_slot = AP; m_slot_k = 1; m_slot_al = 1;
      m_al_after = 1; m_ndata = 0; m_force_p = 0;
      e_data = AP_LO; e_k = 2'b01; e_ph = 0; e_act = 1; e_done = 0;
   endtask

   function automatic bit m_next_is_data();
      if (m_slot_al) return (m_al_after == 0);
      return (m_ndata != INTERVAL) && !m_force_p;
   endfunction

   task automatic model_edge(input bit lu, input bit frc, input logic [31:0] din, input bit disk);
      bit was_al;
      bit start_pair;
      bit sel;
      was_al     = m_slot_al;
      start_pair = 0;
      e_done     = 0;
      if (!lu) begin
         sel    = m_up ? 1'b0 : ~e_ph;
         e_data = sel ? AP_HI : AP_LO;
         e_k    = sel ? 2'b00 : 2'b01;
         e_ph   = sel;
         e_act  = 1;
         m_up = 0; m_half = 0; m_slot = AP; m_slot_k = 1; m_slot_al = 1;
         m_al_after = 1; m_ndata = 0; m_force_p = 0;
      end else begin
         e_ph   = m_half;
         e_data = m_half ? m_slot[31:16] : m_slot[15:0];
         e_k    = (!m_half && m_slot_k) ? 2'b01 : 2'b00;
         e_act  = m_slot_al;
         if (m_half) begin
            if (m_slot_al && m_al_after == 1) begin
               m_al_after = 0;
            end else if (m_slot_al) begin
               e_done = 1;
               m_slot = din; m_slot_k = disk; m_slot_al = 0; m_ndata = 1;
            end else if (m_ndata == INTERVAL || m_force_p) begin
               m_slot = AP; m_slot_k = 1; m_slot_al = 1; m_al_after = 1;
               m_force_p = 0; start_pair = 1;
            end else begin
               m_slot = din; m_slot_k = disk; m_ndata++;
            end
         end
         if (frc && !was_al && !start_pair) m_force_p = 1;
         m_up   = 1;
         m_half = ~m_half;
      end
   endtask

   // ---------------------------------------------------------------------------
   // One PHY_CLK cycle, entered and left just after a falling edge.
   // ---------------------------------------------------------------------------
   task automatic cycle(input bit lu, input bit frc);
      bit acc;
      LINKUP      = lu;
      FORCE_ALIGN = frc;
      #1;
      acc = lu && m_half && m_next_is_data();
      chk("dw_accept", DW_ACCEPT, acc);
      @(posedge PHY_CLK);
      model_edge(lu, frc, TX_DW_IN, TX_DW_ISK);
      #1;
      chk("tx_data", TX_DATA_OUT, e_data);
      chk("tx_charisk", TX_CHARISK_OUT, e_k);
      chk("tx_phase", TX_PHASE, e_ph);
      chk("align_active", ALIGN_ACTIVE, e_act);
      chk("align_done", ALIGN_DONE, e_done);
      if (acc) begin
         TX_DW_IN  = TX_DW_IN + 1;
         TX_DW_ISK = ($urandom_range(0, 7) == 0);
      end
      FORCE_ALIGN = 0;
      @(negedge PHY_CLK);
   endtask

   task automatic run(input int n, input bit lu);
      for (int i = 0; i < n; i++) cycle(lu, 0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_data"}, TX_DATA_OUT, AP_LO);
      chk({tag, "_charisk"}, TX_CHARISK_OUT, 2'b01);
      chk({tag, "_phase"}, TX_PHASE, 1'b0);
      chk({tag, "_active"}, ALIGN_ACTIVE, 1'b1);
      chk({tag, "_done"}, ALIGN_DONE, 1'b0);
      chk({tag, "_accept"}, DW_ACCEPT, 1'b0);
   endtask

   initial begin
      bit found;
      bit lu;
      RESET = 1; LINKUP = 0; FORCE_ALIGN = 0; TX_DW_IN = 32'h00000001; TX_DW_ISK = 0;
      model_reset();
      #2;
      check_reset_values("reset");
      repeat (2) @(negedge PHY_CLK);
      RESET = 0;

      // Link down: ALIGN halves alternate, nothing is accepted.
      run(6, 0);

      // Link up, continuous data through the first automatic pair.
      run(560, 1);

      // Forced pair in the middle of the tenth data DWORD.
      found = 0;
      for (int i = 0; i < 1200 && !found; i++) begin
         if (!m_slot_al && m_ndata == 10 && m_half == 0) begin
            found = 1; cycle(1, 1);
         end else cycle(1, 0);
      end
      chk("reach_force_cnt10", found, 1);
      run(540, 1);

      // Request while the second ALIGN of a pair is on the wire.
      found = 0;
      for (int i = 0; i < 1200 && !found; i++) begin
         if (m_up && m_slot_al && m_al_after == 0) begin
            found = 1; cycle(1, 1);
         end else cycle(1, 0);
      end
      chk("reach_force_align1", found, 1);
      run(20, 1);

      // Request on the very edge the interval expires.
      found = 0;
      for (int i = 0; i < 1200 && !found; i++) begin
         if (!m_slot_al && m_ndata == INTERVAL && m_half == 1) begin
            found = 1; cycle(1, 1);
         end else cycle(1, 0);
      end
      chk("reach_force_expiry", found, 1);
      run(20, 1);

      // Link drop during the high half of a data slot, then re-link.
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (m_up && !m_slot_al && m_half == 1) begin
            found = 1; cycle(0, 0);
         end else cycle(1, 0);
      end
      chk("reach_drop_high", found, 1);
      run(4, 0);
      run(30, 1);

      // Random link flaps and force requests.
      lu = 1;
      for (int i = 0; i < 1500; i++) begin
         if (lu && $urandom_range(0, 299) == 0) lu = 0;
         else if (!lu && $urandom_range(0, 5) == 0) lu = 1;
         cycle(lu, $urandom_range(0, 39) == 0);
      end

      // Reset asserted in the middle of a linked slot.
      run(7, 1);
      #3;
      RESET = 1;
      #1;
      model_reset();
      check_reset_values("midreset");
      @(negedge PHY_CLK);
      RESET = 0;
      run(40, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
